// File: rtl/apb_uart_pkg.sv
// Shared register offsets, bit positions and FSM encodings for the APB UART.
package apb_uart_pkg;
    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_BAUD   = 5'h04;
    localparam logic [4:0] ADDR_TXDATA = 5'h08;
    localparam logic [4:0] ADDR_RXDATA = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_RX_OVR   = 2;
    localparam int STAT_FRM_ERR  = 3;

    localparam logic [15:0] BAUD_DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/apb_uart_if.sv
// APB3 bus bundle between the bench/master and the UART slave.
interface apb_uart_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle result pulses.
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | timing to mid start bit, high sample means glitch
// RX_DATA  | shifting in 8 bits, LSB first
// RX_STOP  | sampling the stop bit, then report byte or framing error
module uart_rx_deser
    import apb_uart_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        RX,
    input  logic        rx_en,
    input  logic [15:0] baud_div,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        rx_frame_err
);
    rx_state_e   rx_state;
    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Start count is two short of half a bit to absorb the synchronizer and edge-detect latency.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_div        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            if (!rx_en) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_div   <= baud_div;
                        rx_cnt   <= (baud_div >> 1) - 16'd2;
                    end
                    RX_START: if (rx_cnt == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_idx   <= '0;
                            rx_cnt   <= rx_div - 16'd1;
                        end
                    end else rx_cnt <= rx_cnt - 16'd1;
                    RX_DATA: if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= rx_div - 16'd1;
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else rx_cnt <= rx_cnt - 16'd1;
                    RX_STOP: if (rx_cnt == '0) begin
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_byte       <= rx_shift;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            rx_frame_err  <= 1'b1;
                        end
                    end else rx_cnt <= rx_cnt - 16'd1;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/apb_uart_core.sv
// APB3 UART slave: register file and 8N1 transmitter; receiver lives in uart_rx_deser.
// state    | meaning
// TX_IDLE  | line high, waiting for an accepted TXDATA write
// TX_START | driving the start bit
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving the stop bit, TX_BUSY drops when it ends
module apb_uart_core
    import apb_uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV_RST = 16'd16,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32
)(
    input  logic       PCLK,
    input  logic       PRESETn,
    apb_uart_if.slave  apb,
    output logic       Tx,
    input  logic       RX
);
    logic              tx_en, rx_en, rx_valid, rx_ovr, frm_err, tx_busy;
    logic [15:0]       baud_div, tx_cnt, tx_div;
    logic [7:0]        rx_data, tx_shift, des_byte;
    logic [2:0]        tx_idx;
    logic              des_valid, des_ferr;
    tx_state_e         tx_state;
    logic [4:0]        off;
    logic              addr_ok, access, commit, wr_commit, rd_clear, tx_load, acc_err;
    logic [DATA_W-1:0] rd_val;
    logic              unused_wdata;

    assign off          = apb.PADDR[4:0];
    assign addr_ok      = (apb.PADDR[1:0] == 2'b00) && (apb.PADDR <= ADDR_W'(ADDR_STATUS));
    assign access       = apb.PSELx && apb.PENABLE;
    assign commit       = access && apb.PREADY && !apb.PSLVERR;
    assign wr_commit    = commit && apb.PWRITE;
    assign rd_clear     = commit && !apb.PWRITE && (off == ADDR_RXDATA);
    assign tx_load      = wr_commit && (off == ADDR_TXDATA);
    assign unused_wdata = ^apb.PWDATA[DATA_W-1:16];

    always_comb begin
        acc_err = 1'b0;
        rd_val  = '0;
        if (!addr_ok) acc_err = 1'b1;
        else begin
            case (off)
                ADDR_CTRL:   rd_val = DATA_W'({rx_en, tx_en});
                ADDR_BAUD: begin
                    rd_val = DATA_W'(baud_div);
                    if (apb.PWRITE && apb.PWDATA[15:0] < BAUD_DIV_MIN) acc_err = 1'b1;
                end
                ADDR_TXDATA: acc_err = !apb.PWRITE || tx_busy || !tx_en;
                ADDR_RXDATA: begin
                    rd_val  = DATA_W'(rx_data);
                    acc_err = apb.PWRITE;
                end
                ADDR_STATUS: rd_val = DATA_W'({frm_err, rx_ovr, rx_valid, tx_busy});
                default:     acc_err = 1'b1;
            endcase
        end
    end

    // One wait state: decode at the end of the first access cycle, commit at the end of the second.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            apb.PRDATA  <= '0;
        end else if (access && !apb.PREADY) begin
            apb.PREADY  <= 1'b1;
            apb.PSLVERR <= acc_err;
            apb.PRDATA  <= (acc_err || apb.PWRITE) ? '0 : rd_val;
        end else begin
            apb.PREADY  <= 1'b0;
            apb.PSLVERR <= 1'b0;
            apb.PRDATA  <= '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            baud_div <= BAUD_DIV_RST;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            frm_err  <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (wr_commit && off == ADDR_CTRL) begin
                tx_en <= apb.PWDATA[CTRL_TX_EN];
                rx_en <= apb.PWDATA[CTRL_RX_EN];
            end
            if (wr_commit && off == ADDR_BAUD) baud_div <= apb.PWDATA[15:0];
            if (wr_commit && off == ADDR_STATUS) begin
                if (apb.PWDATA[STAT_RX_OVR])  rx_ovr  <= 1'b0;
                if (apb.PWDATA[STAT_FRM_ERR]) frm_err <= 1'b0;
            end
            // A byte landing on the same edge as an RXDATA read replaces it without overrun.
            if (des_valid) begin
                if (!rx_valid || rd_clear) begin
                    rx_data  <= des_byte;
                    rx_valid <= 1'b1;
                end else begin
                    rx_ovr   <= 1'b1;
                end
            end else if (rd_clear) begin
                rx_valid <= 1'b0;
            end
            if (des_ferr) frm_err <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state <= TX_IDLE;
            Tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_load) begin
                    tx_state <= TX_START;
                    tx_busy  <= 1'b1;
                    Tx       <= 1'b0;
                    tx_shift <= apb.PWDATA[7:0];
                    tx_div   <= baud_div;
                    tx_cnt   <= baud_div - 16'd1;
                end
                TX_START: if (tx_cnt == '0) begin
                    tx_state <= TX_DATA;
                    Tx       <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_idx   <= '0;
                    tx_cnt   <= tx_div - 16'd1;
                end else tx_cnt <= tx_cnt - 16'd1;
                TX_DATA: if (tx_cnt == '0) begin
                    tx_cnt <= tx_div - 16'd1;
                    if (tx_idx == 3'd7) begin
                        tx_state <= TX_STOP;
                        Tx       <= 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        Tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end else tx_cnt <= tx_cnt - 16'd1;
                TX_STOP: if (tx_cnt == '0) begin
                    tx_state <= TX_IDLE;
                    tx_busy  <= 1'b0;
                end else tx_cnt <= tx_cnt - 16'd1;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx_deser u_rx (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .RX            (RX),
        .rx_en         (rx_en),
        .baud_div      (baud_div),
        .rx_byte       (des_byte),
        .rx_byte_valid (des_valid),
        .rx_frame_err  (des_ferr)
    );
endmodule

// File: tb/tb_apb_uart_core.sv
// Self-checking bench for apb_uart_core: APB register behaviour, TX waveform, RX frames vs a byte-level model.
module tb_apb_uart_core;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic Tx;
    logic RX = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Byte-level reference state of the receive side.
    logic       m_valid, m_ovr, m_ferr;
    logic [7:0] m_data;

    apb_uart_if bus ();

    apb_uart_core dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
        .Tx      (Tx),
        .RX      (RX)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        int waits;
        @(negedge PCLK);
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        waits = 0;
        while (!bus.PREADY && waits < 8) begin
            @(negedge PCLK);
            waits++;
        end
        check_eq("wait_states", waits, 1);
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        @(negedge PCLK);
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd;
        logic err;
        apb_xfer(1'b1, addr, data, rd, err);
        check_eq({tag, "_err"}, err, exp_err);
    endtask

    task automatic apb_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic err;
        apb_xfer(1'b0, addr, 32'h0, rd, err);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_data"}, rd, exp_data);
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        return {28'h0, m_ferr, m_ovr, m_valid, busy};
    endfunction

    // Checks Tx for n cycles starting at the current negedge; cycle k belongs to bit k/bd of the frame.
    task automatic tx_frame_check(input logic [7:0] b, input int bd, input int n);
        logic exp;
        for (int k = 0; k < n; k++) begin
            if (k < bd)          exp = 1'b0;
            else if (k < 9 * bd) exp = b[(k / bd) - 1];
            else                 exp = 1'b1;
            check_eq("tx_bit", Tx, exp);
            @(negedge PCLK);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int bd);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            RX = bits[i];
            repeat (bd - 1) @(negedge PCLK);
        end
        @(negedge PCLK);
        RX = 1'b1;
        repeat (4) @(negedge PCLK);
        if (!stop)         m_ferr = 1'b1;
        else if (m_valid)  m_ovr  = 1'b1;
        else begin
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    task automatic read_rxdata(input string tag);
        apb_rd(tag, 32'h0C, {24'h0, m_data}, 1'b0);
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
    endtask

    initial begin
        logic [7:0] b1, b2;
        int bd;
        logic [31:0] w;
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        model_reset();

        repeat (3) @(negedge PCLK);
        check_eq("rst_prdata", bus.PRDATA, 0);
        check_eq("rst_pready", bus.PREADY, 0);
        check_eq("rst_pslverr", bus.PSLVERR, 0);
        check_eq("rst_tx", Tx, 1);
        PRESETn = 1'b1;

        apb_rd("baud_rst", 32'h04, 32'h10, 1'b0);
        apb_rd("status_rst", 32'h10, 32'h0, 1'b0);
        apb_rd("ctrl_rst", 32'h00, 32'h0, 1'b0);
        apb_wr("txdata_disabled", 32'h08, 32'h55, 1'b1);
        apb_rd("txdata_read", 32'h08, 32'h0, 1'b1);
        apb_wr("rxdata_write", 32'h0C, 32'h12, 1'b1);
        apb_rd("unmapped_14", 32'h14, 32'h0, 1'b1);
        apb_rd("unaligned_02", 32'h02, 32'h0, 1'b1);
        check_eq("tx_idle", Tx, 1);

        apb_wr("ctrl_tx", 32'h00, 32'h1, 1'b0);
        apb_wr("baud4", 32'h04, 32'h4, 1'b0);
        apb_rd("ctrl_rd", 32'h00, 32'h1, 1'b0);
        apb_wr("txdata_a5", 32'h08, 32'hA5, 1'b0);
        tx_frame_check(8'hA5, 4, 41);
        apb_rd("status_after_a5", 32'h10, exp_status(1'b0), 1'b0);

        b1 = 8'($urandom);
        apb_wr("txdata_busy0", 32'h08, {24'h0, b1}, 1'b0);
        fork
            tx_frame_check(b1, 4, 41);
            begin
                repeat (2) @(negedge PCLK);
                apb_wr("txdata_busy", 32'h08, 32'hFF, 1'b1);
                apb_rd("status_busy", 32'h10, exp_status(1'b1), 1'b0);
                apb_wr("baud3", 32'h04, 32'h3, 1'b1);
                apb_rd("baud_keep", 32'h04, 32'h4, 1'b0);
            end
        join

        for (int it = 0; it < 3; it++) begin
            bd = $urandom_range(4, 9);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            apb_wr("baud_rand", 32'h04, bd, 1'b0);
            apb_wr("tx_first", 32'h08, {24'h0, b1}, 1'b0);
            tx_frame_check(b1, bd, 10 * bd - 2);
            apb_wr("tx_back2back", 32'h08, {24'h0, b2}, 1'b0);
            tx_frame_check(b2, bd, 10 * bd + 1);
        end
        apb_rd("status_tx_done", 32'h10, exp_status(1'b0), 1'b0);

        apb_wr("ctrl_rx", 32'h00, 32'h2, 1'b0);
        apb_wr("baud8", 32'h04, 32'h8, 1'b0);
        send_rx(8'h3C, 1'b1, 8);
        apb_rd("status_rx_valid", 32'h10, exp_status(1'b0), 1'b0);
        read_rxdata("rxdata_3c");
        apb_rd("status_rx_cleared", 32'h10, exp_status(1'b0), 1'b0);

        @(negedge PCLK);
        RX = 1'b0;
        repeat (3) @(negedge PCLK);
        RX = 1'b1;
        repeat (40) @(negedge PCLK);
        apb_rd("status_glitch", 32'h10, exp_status(1'b0), 1'b0);

        send_rx(8'h11, 1'b1, 8);
        send_rx(8'h22, 1'b1, 8);
        apb_rd("status_ovr", 32'h10, exp_status(1'b0), 1'b0);
        apb_wr("w1c_ovr", 32'h10, 32'h4, 1'b0);
        m_ovr = 1'b0;
        apb_rd("status_ovr_clr", 32'h10, exp_status(1'b0), 1'b0);
        send_rx(8'h5A, 1'b0, 8);
        apb_rd("status_ferr", 32'h10, exp_status(1'b0), 1'b0);
        read_rxdata("rxdata_11");
        apb_wr("w1c_ferr", 32'h10, 32'h8, 1'b0);
        m_ferr = 1'b0;
        apb_rd("status_ferr_clr", 32'h10, exp_status(1'b0), 1'b0);

        for (int it = 0; it < 12; it++) begin
            bd = $urandom_range(4, 12);
            apb_wr("baud_rx_rand", 32'h04, bd, 1'b0);
            send_rx(8'($urandom), ($urandom_range(0, 4) != 0), bd);
            if ($urandom_range(0, 1) == 1) read_rxdata("rxdata_rand");
            apb_rd("status_rand", 32'h10, exp_status(1'b0), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                w = $urandom_range(0, 15);
                apb_wr("w1c_rand", 32'h10, w, 1'b0);
                if (w[2]) m_ovr  = 1'b0;
                if (w[3]) m_ferr = 1'b0;
            end
        end

        apb_wr("ctrl_tx2", 32'h00, 32'h1, 1'b0);
        apb_wr("txdata_00", 32'h08, 32'h00, 1'b0);
        repeat (20) @(negedge PCLK);
        check_eq("tx_mid_frame", Tx, 0);
        PRESETn = 1'b0;
        #1;
        check_eq("tx_reset_async", Tx, 1);
        model_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        apb_rd("status_post_rst", 32'h10, 32'h0, 1'b0);
        apb_rd("baud_post_rst", 32'h04, 32'h10, 1'b0);
        apb_rd("ctrl_post_rst", 32'h00, 32'h0, 1'b0);
        check_eq("tx_post_rst", Tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
